// File: rtl/seq_div16.sv
// ---------------------------------------------------------------------------
// seq_div16 -- iterative 16-bit integer divider (restoring shift/subtract).
//
// Optional build macro: DIV_SIGNED_EN
//   When defined, signed_op=1 runs a two's-complement truncating divide.
//   The operands are reduced to magnitudes at capture, the unsigned core
//   runs, and the signs are fixed up on the way into FIN.
//   When not defined, signed_op is ignored and no sign logic exists.
//
// Parameters:
//   RADIX_BITS  quotient bits resolved per cycle (1 or 2); N = 16/RADIX_BITS
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   request, accepted only when not busy
//   dividend     in   [15:0] numerator, captured on accepted start
//   divisor      in   [15:0] denominator, captured on accepted start
//   signed_op    in   two's-complement operation (DIV_SIGNED_EN only)
//   busy         out  iteration in progress
//   done         out  one-cycle pulse, results valid
//   quotient     out  [15:0] registered quotient
//   remainder    out  [15:0] registered remainder
//   div_by_zero  out  divisor was zero on the last accepted op
//
// Handshake: start is sampled on every rising edge where the divider is in
// IDLE or FIN (busy=0); while busy=1 start is ignored and nothing queues.
// Results change only on the edge that enters FIN, the same edge that
// raises done for one cycle.
// ---------------------------------------------------------------------------
module seq_div16 #(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  input  logic        signed_op,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero
);

  localparam int         N        = 16 / RADIX_BITS;
  localparam logic [3:0] CNT_INIT = 4'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] rem_q, rem_d;   // partial remainder, always < divisor
  logic [15:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
  logic [15:0] dsr_q, dsr_d;
  logic [15:0] quo_q, quo_d;
  logic [15:0] rmd_q, rmd_d;
  logic        dbz_q, dbz_d;

  logic        accept;
  logic [15:0] mag_a, mag_b;
  logic [15:0] fin_q, fin_r;
  logic [15:0] step_rem, step_dvd;

  assign accept = start && (state_q != CALC);

`ifdef DIV_SIGNED_EN
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;
  logic a_neg, b_neg;

  assign a_neg = signed_op & dividend[15];
  assign b_neg = signed_op & divisor[15];
  assign mag_a = a_neg ? (16'd0 - dividend) : dividend;
  assign mag_b = b_neg ? (16'd0 - divisor)  : divisor;
  // 0x8000 negates to itself, which is the correct magnitude read unsigned.
  assign fin_q = neg_q_q ? (16'd0 - step_dvd) : step_dvd;
  assign fin_r = neg_r_q ? (16'd0 - step_rem) : step_rem;
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign mag_a = dividend;
  assign mag_b = divisor;
  assign fin_q = step_dvd;
  assign fin_r = step_rem;
`endif

  // Restoring iteration(s) for one cycle. The shifted partial remainder is
  // 17 bits wide and the trial difference 18 bits, so bit 17 is the borrow.
  always_comb begin : step_logic
    logic [16:0] shifted;
    logic [17:0] diff;
    step_rem = rem_q;
    step_dvd = dvd_q;
    shifted  = '0;
    diff     = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      shifted  = {1'b0, step_rem[15:0]} << 1 | {16'd0, step_dvd[15]};
      diff     = {1'b0, shifted} - {2'b00, dsr_q};
      step_rem = diff[17] ? shifted[15:0] : diff[15:0];
      step_dvd = {step_dvd[14:0], ~diff[17]};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FIN: begin
        if (start)            state_d = (divisor == 16'd0) ? FIN : CALC;
        else if (state_q == FIN) state_d = IDLE;
      end
      CALC:    if (cnt_q == 4'd0) state_d = FIN;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == CALC);
    done = (state_q == FIN);
  end

  // Datapath next state
  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    dvd_d = dvd_q;
    dsr_d = dsr_q;
    quo_d = quo_q;
    rmd_d = rmd_q;
    dbz_d = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
`endif
    if (accept) begin
      if (divisor == 16'd0) begin
        quo_d = 16'hFFFF;
        rmd_d = dividend;
        dbz_d = 1'b1;
      end else begin
        rem_d = '0;
        dvd_d = mag_a;
        dsr_d = mag_b;
        cnt_d = CNT_INIT;
`ifdef DIV_SIGNED_EN
        neg_q_d = a_neg ^ b_neg;
        neg_r_d = a_neg;
`endif
      end
    end else if (state_q == CALC) begin
      rem_d = step_rem;
      dvd_d = step_dvd;
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd0) begin
        quo_d = fin_q;
        rmd_d = fin_r;
        dbz_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      rem_q <= '0;
      dvd_q <= '0;
      dsr_q <= '0;
      quo_q <= '0;
      rmd_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      dsr_q <= dsr_d;
      quo_q <= quo_d;
      rmd_q <= rmd_d;
      dbz_q <= dbz_d;
    end
  end

`ifdef DIV_SIGNED_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
`endif

  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule
